// File: rtl/uart_cmd_decoder_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder_if
// Groups the receiver-side strobe, the game-side command handshake and the
// status outputs of uart_cmd_decoder into one bundle.
//   master : drives received bytes / frame error / cmd_ready, observes outputs
//   slave  : the decoder itself
// Signals:
//   i_rx_data[7:0], i_rx_valid, i_frame_error, i_cmd_ready  -> decoder
//   o_cmd_valid, o_cmd_dir[1:0], o_pause, o_restart,
//   o_overflow, o_err_count[ERR_CNT_W-1:0]                  <- decoder
// -----------------------------------------------------------------------------
interface uart_cmd_decoder_if #(
  parameter int ERR_CNT_W = 8
);
  logic [7:0]           i_rx_data;
  logic                 i_rx_valid;
  logic                 i_frame_error;
  logic                 i_cmd_ready;
  logic                 o_cmd_valid;
  logic [1:0]           o_cmd_dir;
  logic                 o_pause;
  logic                 o_restart;
  logic                 o_overflow;
  logic [ERR_CNT_W-1:0] o_err_count;

  modport master (
    output i_rx_data, i_rx_valid, i_frame_error, i_cmd_ready,
    input  o_cmd_valid, o_cmd_dir, o_pause, o_restart, o_overflow, o_err_count
  );

  modport slave (
    input  i_rx_data, i_rx_valid, i_frame_error, i_cmd_ready,
    output o_cmd_valid, o_cmd_dir, o_pause, o_restart, o_overflow, o_err_count
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder
// Turns UART bytes into game commands: WASD (either case) become direction
// commands queued in a first-word-fall-through FIFO, space toggles pause,
// R/r issues a one-cycle restart that flushes the queue and clears pause and
// overflow. Directions equal to, or the reverse of, the last accepted
// direction are dropped, as are all directions while paused.
//
// Parameters:
//   FIFO_DEPTH : queued direction commands (power of two, 2..16)
//   ERR_CNT_W  : width of the saturating frame-error counter
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : uart_cmd_decoder_if.slave (rx strobe, cmd handshake, status)
// Build option:
//   UART_CMD_ERR_CNT_EN : when defined, the frame-error edge detector and
//   counter are built; otherwise o_err_count is tied to zero.
// -----------------------------------------------------------------------------
module uart_cmd_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  uart_cmd_decoder_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  // ---------------------------------------------------------------------------
  // Byte decode (only in strobe cycles)
  // ---------------------------------------------------------------------------
  logic is_dir, is_pause, is_restart;
  dir_e dec_dir;

  always_comb begin
    is_dir     = 1'b0;
    is_pause   = 1'b0;
    is_restart = 1'b0;
    dec_dir    = DIR_UP;
    if (bus.i_rx_valid) begin
      case (bus.i_rx_data)
        8'h57, 8'h77: begin is_dir = 1'b1; dec_dir = DIR_UP;    end
        8'h53, 8'h73: begin is_dir = 1'b1; dec_dir = DIR_DOWN;  end
        8'h41, 8'h61: begin is_dir = 1'b1; dec_dir = DIR_LEFT;  end
        8'h44, 8'h64: begin is_dir = 1'b1; dec_dir = DIR_RIGHT; end
        8'h20:        is_pause   = 1'b1;
        8'h52, 8'h72: is_restart = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  dir_e          r_last_dir;
  logic          r_pause, r_restart, r_overflow;

  logic empty, full, pop, dir_ok, push, drop_full;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign pop   = !empty && bus.i_cmd_ready;

  // Reversal of a direction is the same axis with the low bit flipped.
  assign dir_ok    = is_dir && !r_pause && (dec_dir != r_last_dir) &&
                     (dec_dir != (r_last_dir ^ 2'b01));
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push      = dir_ok && (!full || pop);
  assign drop_full = dir_ok && full && !pop;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_last_dir <= DIR_RIGHT;
      r_pause    <= 1'b0;
      r_restart  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_restart <= is_restart;
      if (is_restart) begin
        // Flush wins over any pop presented in the same cycle.
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_last_dir <= DIR_RIGHT;
        r_pause    <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        if (push) begin
          r_wr_ptr   <= r_wr_ptr + PW'(1);
          r_last_dir <= dec_dir;
        end
        if (pop)       r_rd_ptr   <= r_rd_ptr + PW'(1);
        if (drop_full) r_overflow <= 1'b1;
        if (is_pause)  r_pause    <= ~r_pause;
      end
    end
  end

  // Storage needs no reset; validity is carried by the pointers.
  always_ff @(posedge i_clk) begin
    if (push) mem[r_wr_ptr[AW-1:0]] <= dec_dir;
  end

  assign bus.o_cmd_valid = !empty;
  assign bus.o_cmd_dir   = empty ? 2'b00 : mem[r_rd_ptr[AW-1:0]];
  assign bus.o_pause     = r_pause;
  assign bus.o_restart   = r_restart;
  assign bus.o_overflow  = r_overflow;

  // ---------------------------------------------------------------------------
  // Frame-error counter (optional). The receiver holds i_frame_error high
  // until the next good byte, so only rising edges are counted.
  // ---------------------------------------------------------------------------
`ifdef UART_CMD_ERR_CNT_EN
  logic                 r_fe_q;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fe_q    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_fe_q <= bus.i_frame_error;
      if (bus.i_frame_error && !r_fe_q && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign bus.o_err_count = r_err_cnt;
`else
  logic unused_fe;
  assign unused_fe       = bus.i_frame_error;
  assign bus.o_err_count = '0;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_decoder
// Directed scenarios followed by randomized byte/handshake/frame-error traffic.
// A queue-based reference model predicts the FIFO contents and status flags;
// expected popped commands go to a scoreboard queue that a negedge monitor
// drains whenever the DUT presents a command that is being accepted.
// -----------------------------------------------------------------------------
module tb_uart_cmd_decoder;
  localparam int DEPTH = 4;
  localparam int ERR_W = 2;
  localparam int CNT_MAX = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_decoder_if #(.ERR_CNT_W(ERR_W)) bus ();

  uart_cmd_decoder #(.FIFO_DEPTH(DEPTH), .ERR_CNT_W(ERR_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: current state (matches DUT outputs now) and next state.
  logic [1:0] m_q[$], n_q[$];
  logic [1:0] exp_q[$];
  logic       m_pause, m_ovf, m_rp, m_fe;
  logic       n_pause, n_ovf, n_rp, n_fe;
  logic [1:0] m_last, n_last;
  int         m_cnt, n_cnt;
  bit         mon_en = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endfunction

  function automatic int dir_of(input logic [7:0] b);
    case (b)
      "w", "W": return 0;
      "s", "S": return 1;
      "a", "A": return 2;
      "d", "D": return 3;
      default:  return -1;
    endcase
  endfunction

  // One clock cycle: drive inputs, predict, advance, commit prediction.
  task automatic cyc(input logic rn, input logic v, input logic [7:0] d,
                     input logic rdy, input logic fe);
    int  dd;
    bit  pop;
    rst_n             = rn;
    bus.i_rx_valid    = v;
    bus.i_rx_data     = d;
    bus.i_cmd_ready   = rdy;
    bus.i_frame_error = fe;
    n_q = m_q; n_pause = m_pause; n_ovf = m_ovf; n_last = m_last;
    n_cnt = m_cnt; n_fe = m_fe; n_rp = 1'b0;
    if (!rn) begin
      n_q.delete(); n_pause = 1'b0; n_ovf = 1'b0; n_last = 2'd3;
      n_cnt = 0; n_fe = 1'b0;
    end else begin
      dd  = v ? dir_of(d) : -1;
      pop = (m_q.size() > 0) && rdy;
      if (pop) exp_q.push_back(m_q[0]);
      n_rp = v && (d == 8'h52 || d == 8'h72);
      if (n_rp) begin
        n_q.delete(); n_pause = 1'b0; n_ovf = 1'b0; n_last = 2'd3;
      end else begin
        if (pop) void'(n_q.pop_front());
        if (dd >= 0 && !m_pause && dd != int'(m_last) && dd != int'(m_last ^ 2'b01)) begin
          if (m_q.size() < DEPTH || pop) begin
            n_q.push_back(dd[1:0]);
            n_last = dd[1:0];
          end else begin
            n_ovf = 1'b1;
          end
        end
        if (v && d == 8'h20) n_pause = !m_pause;
      end
      if (fe && !m_fe) n_cnt = (m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1;
      n_fe = fe;
    end
    @(posedge clk);
    #1;
    if (mon_en) begin
      chk("pop_consumed", exp_q.size(), 0);
      exp_q.delete();
    end
    m_q = n_q; m_pause = n_pause; m_ovf = n_ovf; m_rp = n_rp;
    m_last = n_last; m_cnt = n_cnt; m_fe = n_fe;
    mon_en = 1'b1;
  endtask

  task automatic byte_in(input logic [7:0] d, input logic rdy);
    cyc(1'b1, 1'b1, d, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Monitor: compare visible state to the model, drain scoreboard on accept.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("cmd_valid", bus.o_cmd_valid, m_q.size() > 0);
      chk("pause", bus.o_pause, m_pause);
      chk("restart", bus.o_restart, m_rp);
      chk("overflow", bus.o_overflow, m_ovf);
`ifdef UART_CMD_ERR_CNT_EN
      chk("err_count", bus.o_err_count, m_cnt);
`else
      chk("err_count", bus.o_err_count, 0);
`endif
      if (rst_n && bus.o_cmd_valid && bus.i_cmd_ready) begin
        if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
        else chk("cmd_dir", bus.o_cmd_dir, exp_q.pop_front());
      end
    end
  end

  logic [7:0] pick_tbl [16];

  initial begin
    bus.i_rx_valid = 1'b0; bus.i_rx_data = 8'h00;
    bus.i_cmd_ready = 1'b0; bus.i_frame_error = 1'b0;

    // Reset state
    do_reset();
    chk("reset_dir", bus.o_cmd_dir, 2'b00);

    // 'w' then pop
    byte_in("w", 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // 'a' reversal dropped; w,d,d -> UP,RIGHT
    do_reset();
    byte_in("a", 1'b0);
    byte_in("w", 1'b0); byte_in("d", 1'b0); byte_in("d", 1'b0);
    idle(3, 1'b1);

    // Overflow with alternating w/d, then drain
    do_reset();
    for (int i = 0; i < 6; i++) begin
      byte_in("w", 1'b0);
      byte_in("d", 1'b0);
    end
    idle(5, 1'b1);

    // Full FIFO with simultaneous pop accepts the push
    do_reset();
    byte_in("w", 1'b0); byte_in("d", 1'b0); byte_in("w", 1'b0); byte_in("d", 1'b0);
    byte_in("w", 1'b1);
    idle(5, 1'b1);

    // Pause gating
    do_reset();
    byte_in(8'h20, 1'b0); byte_in("s", 1'b0);
    byte_in(8'h20, 1'b0); byte_in("s", 1'b0);
    idle(2, 1'b1);

    // Restart with queued commands while paused, restart vs pop
    do_reset();
    byte_in("w", 1'b0); byte_in("d", 1'b0); byte_in(8'h20, 1'b0);
    byte_in(8'h52, 1'b1);
    byte_in("a", 1'b0);
    idle(2, 1'b1);

    // Frame-error edges: 3 high, low, high -> 2; then saturate
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    byte_in("r", 1'b0);   // restart keeps the counter
    idle(2, 1'b0);

    // Reset mid-operation with a strobe during reset
    byte_in("w", 1'b0); byte_in("d", 1'b0);
    cyc(1'b0, 1'b1, "s", 1'b1, 1'b0);
    idle(2, 1'b1);

    // Randomized traffic
    pick_tbl = '{"w", "s", "a", "d", "W", "S", "A", "D",
                 "w", "d", "s", "a", 8'h20, "r", "R", 8'h00};
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] b;
      logic v, rdy, fe, rn;
      int k;
      k   = $urandom_range(0, 15);
      b   = (k == 15) ? 8'($urandom) : pick_tbl[k];
      if (k == 13 || k == 14) b = ($urandom_range(0, 7) == 0) ? b : "d";
      v   = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 4);
      fe  = ($urandom_range(0, 9) < 2) ? ~m_fe : m_fe;
      rn  = ($urandom_range(0, 499) != 0);
      cyc(rn, v, b, rdy, fe);
    end
    idle(DEPTH + 2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
- REQ-001: Parameter FIFO_DEPTH, default 4; number of queued direction commands; power of two, range 2..16.
- REQ-002: Parameter ERR_CNT_W, default 8; width of the frame-error counter.
- REQ-003: i_clk  input  1  single system clock; all logic is on the rising edge.
- REQ-004: i_rst_n  input  1  reset, synchronous, active-low.
- REQ-005: i_rx_data  input  8  received byte from the UART receiver.
- REQ-006: i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid in that cycle.
- REQ-007: i_frame_error  input  1  frame-error level from the receiver; it stays high until the next good byte.
- REQ-008: i_cmd_ready  input  1  game logic accepts the head command this cycle.
- REQ-009: o_cmd_valid  output  1  a direction command is at the FIFO head.
- REQ-010: o_cmd_dir  output  2  head direction: UP=00, DOWN=01, LEFT=10, RIGHT=11.
- REQ-011: o_pause  output  1  pause level.
- REQ-012: o_restart  output  1  one-cycle restart pulse.
- REQ-013: o_overflow  output  1  sticky flag: a direction was dropped because the FIFO was full.
- REQ-014: o_err_count  output  ERR_CNT_W  saturating count of frame errors.

Function
- REQ-015: Bytes are decoded only in cycles where i_rx_valid=1; all other cycles cause no decode action.
- REQ-016: Byte mapping:
  - 0x57/0x77 -> UP
  - 0x53/0x73 -> DOWN
  - 0x41/0x61 -> LEFT
  - 0x44/0x64 -> RIGHT
  - 0x20 -> pause toggle
  - 0x52/0x72 -> restart
  - all other bytes are ignored with no state change.
- REQ-017: The decoder keeps r_last_dir, the last direction accepted into the FIFO, with reset value RIGHT.
- REQ-018: A direction is dropped if it equals r_last_dir.
- REQ-019: A direction is dropped if it equals r_last_dir XOR 2'b01 (reversal).
- REQ-020: A direction is dropped while o_pause=1.
- REQ-021: A direction that passes REQ-018..REQ-020 is pushed into the FIFO and updates r_last_dir, provided the FIFO is not full.
- REQ-022: A push into a full FIFO is dropped, r_last_dir is unchanged, and o_overflow is set.
- REQ-023: If the FIFO is full and a pop occurs in the same cycle as a push, the push is accepted.
- REQ-024: The FIFO is first-word-fall-through: o_cmd_valid = not empty, and o_cmd_dir = head entry.
- REQ-025: A pop occurs when o_cmd_valid=1 and i_cmd_ready=1.
- REQ-026: Latency: a direction byte strobed in cycle N into an empty FIFO gives o_cmd_valid=1 in cycle N+1.
- REQ-027: When the FIFO is empty, i_cmd_ready is ignored.
- REQ-028: Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full is detected from the MSB difference.
- REQ-029: Pause byte: o_pause inverts in the next cycle. Queued commands remain and can still be popped.
- REQ-030: Restart byte: in the next cycle o_restart=1 for exactly one cycle.
- REQ-031: Restart byte: in the same next cycle the FIFO is flushed (empty), o_pause=0, o_overflow=0 and r_last_dir=RIGHT.
- REQ-032: A restart takes priority over a pop in the same cycle.
- REQ-033: Each rising edge of i_frame_error (0 in the previous cycle, 1 in the current cycle) increments o_err_count, saturating at all-ones.
- REQ-034: Restart does not clear o_err_count.

Reset
- REQ-035: While i_rst_n=0 at a clock edge, the following are cleared:
  - o_cmd_valid=0, o_cmd_dir=00
  - o_pause=0, o_restart=0, o_overflow=0
  - o_err_count=0
  - FIFO empty, r_last_dir=RIGHT, frame-error edge register=0.
- REQ-036: Reset asserted mid-operation discards queued commands; a strobe arriving during reset is ignored.

Configuration
- REQ-037: Macro UART_CMD_ERR_CNT_EN controls the frame-error counter.
  - Defined: the frame-error edge detector and counter are built, per REQ-033.
  - Undefined: no counter logic is built, and o_err_count is constant 0.

Verification
- REQ-038: After reset, strobe 0x77 ('w') -> next cycle o_cmd_valid=1, o_cmd_dir=00; i_cmd_ready=1 -> o_cmd_valid=0 the cycle after.
- REQ-039: From reset, strobe 'a' (0x61) -> command is dropped (reversal of RIGHT), o_cmd_valid stays 0. Then 'w','d','d' -> FIFO holds UP,RIGHT only (the second 'd' is a duplicate).
- REQ-040: FIFO_DEPTH=4, i_cmd_ready=0, alternate 'w','d' six times -> four entries queued and o_overflow=1. Then pop four times -> UP,RIGHT,UP,RIGHT.
- REQ-041: Strobe 0x20 -> o_pause=1; then 's' -> dropped; then 0x20 -> o_pause=0; then 's' -> queued DOWN.
- REQ-042: Two queued commands and o_pause=1, strobe 0x52 -> one-cycle o_restart; FIFO empty, o_pause=0, o_overflow=0, next 'a' dropped.
- REQ-043: With UART_CMD_ERR_CNT_EN defined, i_frame_error high for 3 cycles, then low, then high -> o_err_count=2; with ERR_CNT_W=2 and five pulses -> 3. With the macro undefined -> o_err_count remains 0.
